// File: rtl/case_9_div_pkg.sv
// Shared definitions for the sequential signed divider: FSM state encoding,
// default operand widths and the bit-counter width helper.
package case_9_div_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam int DIN0_WIDTH_DEF = 8;
    localparam int DIN1_WIDTH_DEF = 6;
    localparam int DOUT_WIDTH_DEF = 8;

    // Counter must be able to hold the value din0_width itself.
    function automatic int cnt_width(input int din0_width);
        return $clog2(din0_width + 1);
    endfunction

    localparam int CNT_WIDTH_DEF = cnt_width(DIN0_WIDTH_DEF);

endpackage

// File: rtl/case_9_sdiv_step.sv
// One restoring-division step on unsigned magnitudes: shift the next dividend
// bit into the partial remainder, trial-subtract the divisor, keep the
// difference if it did not go negative.
module case_9_sdiv_step #(
    parameter int W = 6
) (
    input  logic [W-1:0] rem_i,
    input  logic         bit_i,
    input  logic [W-1:0] dvs_i,
    output logic [W-1:0] rem_o,
    output logic         q_bit_o
);

    logic [W:0]   shifted;
    logic [W-1:0] diff;

    // The partial remainder never exceeds the divisor magnitude minus one, so
    // the difference always fits in W bits when the subtraction is taken.
    assign shifted = {rem_i, bit_i};
    assign q_bit_o = (shifted >= {1'b0, dvs_i});
    assign diff    = shifted[W-1:0] - dvs_i;
    assign rem_o   = q_bit_o ? diff : shifted[W-1:0];

endmodule

// File: rtl/case_9_sdiv_8s_6s_8_seq.sv
// Sequential signed divider: one quotient bit per cycle, truncating toward
// zero, valid/ready handshakes on both sides. Latency from acceptance to
// out_vld is always din0_WIDTH edges.
// Optional feature: define CASE_9_SDIV_DIVZERO_FLAG_EN to add the dz output
// (divide-by-zero flag, registered alongside quot).
module case_9_sdiv_8s_6s_8_seq
    import case_9_div_pkg::*;
#(
    parameter int din0_WIDTH = DIN0_WIDTH_DEF,
    parameter int din1_WIDTH = DIN1_WIDTH_DEF,
    parameter int dout_WIDTH = DOUT_WIDTH_DEF
) (
    input  logic                  ap_clk,
    input  logic                  ap_rst,
    input  logic                  in_vld,
    output logic                  in_rdy,
    input  logic [din0_WIDTH-1:0] din0,
    input  logic [din1_WIDTH-1:0] din1,
    output logic                  out_vld,
    input  logic                  out_rdy,
    output logic [dout_WIDTH-1:0] quot,
    output logic [din1_WIDTH-1:0] remd
`ifdef CASE_9_SDIV_DIVZERO_FLAG_EN
    ,
    output logic                  dz
`endif
);

    localparam int CNT_W = cnt_width(din0_WIDTH);

    state_t state_q, state_d;

    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [din0_WIDTH-1:0] dq_q, dq_d;          // dividend bits out, quotient bits in
    logic [din1_WIDTH-1:0] rem_q, rem_d;        // partial remainder magnitude
    logic [din1_WIDTH-1:0] dvs_q, dvs_d;        // divisor magnitude
    logic [din1_WIDTH-1:0] dvd_low_q, dvd_low_d; // raw dividend low bits for /0
    logic                  dvd_neg_q, dvd_neg_d;
    logic                  dvs_neg_q, dvs_neg_d;
    logic                  dvs_zero_q, dvs_zero_d;
    logic [dout_WIDTH-1:0] quot_q, quot_d;
    logic [din1_WIDTH-1:0] remd_q, remd_d;
`ifdef CASE_9_SDIV_DIVZERO_FLAG_EN
    logic                  dz_q, dz_d;
`endif

    logic                  calc_last;
    logic                  q_bit;
    logic [din1_WIDTH-1:0] rem_nxt;
    logic [din0_WIDTH-1:0] q_final;
    logic [dout_WIDTH-1:0] q_mag_ext;

    case_9_sdiv_step #(
        .W (din1_WIDTH)
    ) u_step (
        .rem_i   (rem_q),
        .bit_i   (dq_q[din0_WIDTH-1]),
        .dvs_i   (dvs_q),
        .rem_o   (rem_nxt),
        .q_bit_o (q_bit)
    );

    assign calc_last = (cnt_q == CNT_W'(din0_WIDTH - 1));
    assign q_final   = {dq_q[din0_WIDTH-2:0], q_bit};
    assign q_mag_ext = dout_WIDTH'(q_final);

    // FSM state register; reset wins over any handshake on the same edge.
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state: accept in IDLE, count through CALC, wait for out_rdy.
    // NOTE: every combinational output gets a default first so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (in_vld)  state_d = ST_CALC;
            ST_CALC: if (calc_last) state_d = ST_DONE;
            ST_DONE: if (out_rdy) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM outputs: handshake flags decoded directly from the state.
    always_comb begin
        in_rdy  = (state_q == ST_IDLE);
        out_vld = (state_q == ST_DONE);
    end

    // Datapath next-state: load magnitudes on acceptance, step in CALC,
    // sign-correct and publish the result on the final step.
    always_comb begin
        cnt_d      = cnt_q;
        dq_d       = dq_q;
        rem_d      = rem_q;
        dvs_d      = dvs_q;
        dvd_low_d  = dvd_low_q;
        dvd_neg_d  = dvd_neg_q;
        dvs_neg_d  = dvs_neg_q;
        dvs_zero_d = dvs_zero_q;
        quot_d     = quot_q;
        remd_d     = remd_q;
`ifdef CASE_9_SDIV_DIVZERO_FLAG_EN
        dz_d       = dz_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (in_vld) begin
                    dvd_neg_d  = din0[din0_WIDTH-1];
                    dvs_neg_d  = din1[din1_WIDTH-1];
                    // The most negative dividend negates to itself, which is
                    // exactly its unsigned magnitude.
                    dq_d       = din0[din0_WIDTH-1] ? -din0 : din0;
                    dvs_d      = din1[din1_WIDTH-1] ? -din1 : din1;
                    dvs_zero_d = (din1 == '0);
                    dvd_low_d  = din0[din1_WIDTH-1:0];
                    rem_d      = '0;
                    cnt_d      = '0;
                end
            end
            ST_CALC: begin
                dq_d  = q_final;
                rem_d = rem_nxt;
                cnt_d = cnt_q + CNT_W'(1);
                if (calc_last) begin
                    if (dvs_zero_q) begin
                        quot_d = '1;
                        remd_d = dvd_low_q;
                    end else begin
                        quot_d = (dvd_neg_q ^ dvs_neg_q) ? -q_mag_ext : q_mag_ext;
                        remd_d = dvd_neg_q ? -rem_nxt : rem_nxt;
                    end
`ifdef CASE_9_SDIV_DIVZERO_FLAG_EN
                    dz_d = dvs_zero_q;
`endif
                end
            end
            default: ;
        endcase
    end

    // Datapath registers; reset discards any in-flight operation.
    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            cnt_q      <= '0;
            dq_q       <= '0;
            rem_q      <= '0;
            dvs_q      <= '0;
            dvd_low_q  <= '0;
            dvd_neg_q  <= 1'b0;
            dvs_neg_q  <= 1'b0;
            dvs_zero_q <= 1'b0;
            quot_q     <= '0;
            remd_q     <= '0;
`ifdef CASE_9_SDIV_DIVZERO_FLAG_EN
            dz_q       <= 1'b0;
`endif
        end else begin
            cnt_q      <= cnt_d;
            dq_q       <= dq_d;
            rem_q      <= rem_d;
            dvs_q      <= dvs_d;
            dvd_low_q  <= dvd_low_d;
            dvd_neg_q  <= dvd_neg_d;
            dvs_neg_q  <= dvs_neg_d;
            dvs_zero_q <= dvs_zero_d;
            quot_q     <= quot_d;
            remd_q     <= remd_d;
`ifdef CASE_9_SDIV_DIVZERO_FLAG_EN
            dz_q       <= dz_d;
`endif
        end
    end

    assign quot = quot_q;
    assign remd = remd_q;
`ifdef CASE_9_SDIV_DIVZERO_FLAG_EN
    assign dz   = dz_q;
`endif

endmodule

// File: tb/tb_case_9_sdiv_8s_6s_8_seq.sv
// Scoreboard bench for the sequential signed divider. The driver pushes the
// expected result on each acceptance; an independent monitor compares every
// cycle the DUT presents out_vld, including latency and hold-while-stalled.
module tb_case_9_sdiv_8s_6s_8_seq;

    localparam int W0 = 8;
    localparam int W1 = 6;
    localparam int WQ = 8;
    localparam int LATENCY = 8;

    typedef struct {
        logic [WQ-1:0] quot;
        logic [W1-1:0] remd;
        logic          dz;
        int            acc_cyc;
    } exp_t;

    logic          ap_clk = 1'b0;
    logic          ap_rst;
    logic          in_vld;
    logic          in_rdy;
    logic [W0-1:0] din0;
    logic [W1-1:0] din1;
    logic          out_vld;
    logic          out_rdy;
    logic [WQ-1:0] quot;
    logic [W1-1:0] remd;
`ifdef CASE_9_SDIV_DIVZERO_FLAG_EN
    logic          dz;
`endif

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    bit   seen_cur = 1'b0;

    case_9_sdiv_8s_6s_8_seq dut (
        .ap_clk  (ap_clk),
        .ap_rst  (ap_rst),
        .in_vld  (in_vld),
        .in_rdy  (in_rdy),
        .din0    (din0),
        .din1    (din1),
        .out_vld (out_vld),
        .out_rdy (out_rdy),
        .quot    (quot),
        .remd    (remd)
`ifdef CASE_9_SDIV_DIVZERO_FLAG_EN
        ,
        .dz      (dz)
`endif
    );

    always #5 ap_clk = ~ap_clk;

    always @(posedge ap_clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Reference: plain integer division truncates toward zero and % takes the
    // dividend's sign; results wrap to the port widths.
    function automatic exp_t model(input logic [W0-1:0] a, input logic [W1-1:0] b);
        exp_t e;
        int sa, sb, q, r;
        sa = $signed(a);
        sb = $signed(b);
        e.acc_cyc = 0;
        if (sb == 0) begin
            e.quot = '1;
            e.remd = a[W1-1:0];
            e.dz   = 1'b1;
        end else begin
            q = sa / sb;
            r = sa % sb;
            e.quot = q[WQ-1:0];
            e.remd = r[W1-1:0];
            e.dz   = 1'b0;
        end
        return e;
    endfunction

    // Monitor: compare whenever the DUT presents a result; pop on handshake.
    always @(negedge ap_clk) begin
        if (ap_rst) begin
            exp_q.delete();
            seen_cur = 1'b0;
        end else if (out_vld) begin
            if (exp_q.size() == 0) begin
                check("unexpected_out_vld", 32'(out_vld), 32'd0);
            end else begin
                if (!seen_cur) begin
                    check("latency", 32'(cyc - exp_q[0].acc_cyc), 32'(LATENCY));
                    seen_cur = 1'b1;
                end
                check("quot", 32'(quot), 32'(exp_q[0].quot));
                check("remd", 32'(remd), 32'(exp_q[0].remd));
`ifdef CASE_9_SDIV_DIVZERO_FLAG_EN
                check("dz", 32'(dz), 32'(exp_q[0].dz));
`endif
                if (out_rdy) begin
                    void'(exp_q.pop_front());
                    seen_cur = 1'b0;
                end
            end
        end
    end

    task automatic tick();
        @(posedge ap_clk);
        #1;
    endtask

    // Issue one operation, optionally stall the result for `hold` cycles,
    // then consume it and confirm in_rdy returns exactly one cycle later.
    task automatic run_op(input logic [W0-1:0] a, input logic [W1-1:0] b, input int hold);
        exp_t e;
        int   k;
        din0   = a;
        din1   = b;
        in_vld = 1'b1;
        k = 0;
        while (!in_rdy && k < 50) begin
            tick();
            k++;
        end
        if (!in_rdy) begin
            check("in_rdy_timeout", 32'(in_rdy), 32'd1);
            in_vld = 1'b0;
            return;
        end
        tick();
        e = model(a, b);
        e.acc_cyc = cyc;
        exp_q.push_back(e);
        // Junk operands and in_vld while busy must be ignored.
        din0   = W0'($urandom);
        din1   = W1'($urandom);
        in_vld = 1'($urandom);
        k = 0;
        while (!out_vld && k < 3 * LATENCY) begin
            tick();
            k++;
        end
        in_vld = 1'b0;
        if (!out_vld) begin
            check("out_vld_timeout", 32'(out_vld), 32'd1);
            return;
        end
        for (int i = 0; i < hold; i++) begin
            check("in_rdy_stalled", 32'(in_rdy), 32'd0);
            tick();
        end
        out_rdy = 1'b1;
        tick();
        out_rdy = 1'b0;
        check("in_rdy_after_pop", 32'(in_rdy), 32'd1);
        check("out_vld_after_pop", 32'(out_vld), 32'd0);
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_in_rdy"}, 32'(in_rdy), 32'd1);
        check({tag, "_out_vld"}, 32'(out_vld), 32'd0);
        check({tag, "_quot"}, 32'(quot), 32'd0);
        check({tag, "_remd"}, 32'(remd), 32'd0);
`ifdef CASE_9_SDIV_DIVZERO_FLAG_EN
        check({tag, "_dz"}, 32'(dz), 32'd0);
`endif
    endtask

    initial begin
        ap_rst  = 1'b1;
        in_vld  = 1'b0;
        out_rdy = 1'b0;
        din0    = '0;
        din1    = '0;
        repeat (3) tick();
        ap_rst = 1'b0;
        check_reset_state("reset");

        // Directed cases, including the signed boundaries.
        run_op(8'd100, 6'd7, 0);
        run_op(-8'sd100, 6'd7, 1);
        run_op(8'd127, -6'sd32, 0);
        run_op(-8'sd128, -6'sd1, 0);
        run_op(8'd5, 6'd0, 0);
        run_op(-8'sd5, 6'd0, 0);
        run_op(-8'sd128, 6'd1, 0);
        run_op(-8'sd128, -6'sd32, 0);
        run_op(8'd0, -6'sd32, 0);
        run_op(-8'sd1, 6'd31, 0);
        run_op(8'd127, 6'd1, 0);

        // Backpressure: result held for 5 stalled cycles.
        run_op(8'd100, 6'd7, 5);

        // Randomized operands and consumer stalls.
        for (int i = 0; i < 150; i++) begin
            run_op(W0'($urandom), W1'($urandom), int'($urandom_range(0, 3)));
        end

        // Reset mid-CALC, asserted so it lands on the 4th edge after acceptance.
        din0   = 8'd77;
        din1   = 6'd3;
        in_vld = 1'b1;
        tick();
        in_vld = 1'b0;
        begin
            exp_t e;
            e = model(8'd77, 6'd3);
            e.acc_cyc = cyc;
            exp_q.push_back(e);
        end
        repeat (3) tick();
        ap_rst = 1'b1;
        tick();
        ap_rst = 1'b0;
        check_reset_state("mid_calc_reset");
        repeat (12) tick();
        check("no_ghost_result", 32'(out_vld), 32'd0);
        run_op(8'd100, 6'd7, 0);

        // Reset wins over an in_vld handshake on the same edge.
        din0   = 8'd9;
        din1   = 6'd2;
        in_vld = 1'b1;
        ap_rst = 1'b1;
        tick();
        ap_rst = 1'b0;
        in_vld = 1'b0;
        check("rst_vs_in_vld_in_rdy", 32'(in_rdy), 32'd1);
        repeat (12) tick();
        check("rst_vs_in_vld_no_out", 32'(out_vld), 32'd0);

        repeat (2) tick();
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
